// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable Mealy sequence detector (din/din_valid stream in; cfg_pattern/cfg_len/cfg_overlap loaded by cfg_load; match, saturating match_count, armed out)
module seq_detect_prog #(
    parameter int SYM_W = 1,
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic [SYM_W-1:0]         din,
    input  logic                     cfg_load,
    input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_overlap,
    output logic                     match,
    output logic [CNT_W-1:0]         match_count,
    output logic                     armed
);
    typedef enum logic [1:0] {DISABLED, PRIMING, ARMED} ctl_t;
    logic [MAX_LEN*SYM_W-1:0]     pat;
    logic [LEN_W-1:0]             len;
    logic [LEN_W-1:0]             fill;
    logic                         ovl;
    logic [(MAX_LEN-1)*SYM_W-1:0] hist;
    logic [MAX_LEN*SYM_W-1:0]     shifted;
    logic [CNT_W-1:0]             cnt;
    ctl_t                         ctl;
    logic                         hit;
    logic                         accept;
    assign accept      = din_valid & ~cfg_load;
    assign shifted     = {hist, din};
    assign match       = accept & (ctl == ARMED) & hit;
    assign armed       = ctl == ARMED;
    assign match_count = cnt;
    always_comb begin
        ctl = (len == '0 || len > LEN_W'(MAX_LEN)) ? DISABLED :
              (({1'b0, fill} + 1'b1) >= {1'b0, len} ? ARMED : PRIMING);
        hit = din == pat[SYM_W-1:0];
        for (int i = 1; i < MAX_LEN; i++)
            if (i < int'(len)) hit = hit & (hist[(i-1)*SYM_W +: SYM_W] == pat[i*SYM_W +: SYM_W]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pat  <= '0;
            len  <= '0;
            ovl  <= 1'b0;
            hist <= '0;
            fill <= '0;
            cnt  <= '0;
        end else if (cfg_load) begin
            pat  <= cfg_pattern;
            len  <= cfg_len;
            ovl  <= cfg_overlap;
            fill <= '0;
            cnt  <= '0;
        end else if (din_valid) begin
            hist <= shifted[(MAX_LEN-1)*SYM_W-1:0];
            fill <= (match & ~ovl) ? '0 : (fill == LEN_W'(MAX_LEN) ? fill : fill + 1'b1);
            if (match && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed and random checks of seq_detect_prog against a sliding-window reference model
module tb_seq_detect_prog;
    localparam int SW = 2;
    localparam int ML = 8;
    localparam int CW = 3;
    localparam int LW = 4;
    localparam int CMAX = 7;
    logic            clk = 0;
    logic            rst = 1;
    logic            din_valid = 0;
    logic [SW-1:0]   din = '0;
    logic            cfg_load = 0;
    logic [ML*SW-1:0] cfg_pattern = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cfg_overlap = 0;
    logic            match;
    logic [CW-1:0]   match_count;
    logic            armed;
    int n_chk = 0;
    int n_fail = 0;
    int hits;
    int m_len = 0;
    bit m_ovl = 0;
    int m_cnt = 0;
    int m_seq[$];
    int m_q[$];
    int pend_len;
    bit pend_ovl;
    int pend_seq[$];
    seq_detect_prog #(.SYM_W(SW), .MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .match(match), .match_count(match_count), .armed(armed)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit enabled();
        return m_len >= 1 && m_len <= ML;
    endfunction
    function automatic bit m_armed();
        return enabled() && m_q.size() >= m_len - 1;
    endfunction
    function automatic bit model_match(input bit v, input int d, input bit ld);
        if (!v || ld || !m_armed()) return 0;
        for (int j = 0; j < m_len - 1; j++)
            if (m_q[m_q.size() - (m_len - 1) + j] != m_seq[j]) return 0;
        return d == m_seq[m_len - 1];
    endfunction
    task automatic step(input bit v, input int d, input bit ld = 0, input bit r = 0);
        bit em;
        @(negedge clk);
        rst = r;
        din_valid = v;
        din = d[SW-1:0];
        cfg_load = ld;
        #1;
        em = !r && model_match(v, d, ld);
        check("match", {31'b0, match}, {31'b0, em});
        if (em) hits++;
        @(posedge clk);
        #1;
        if (r) begin
            m_len = 0;
            m_ovl = 0;
            m_cnt = 0;
            m_seq.delete();
            m_q.delete();
        end else if (ld) begin
            m_len = pend_len;
            m_ovl = pend_ovl;
            m_seq = pend_seq;
            m_cnt = 0;
            m_q.delete();
        end else if (v) begin
            if (em && m_cnt < CMAX) m_cnt++;
            if (em && !m_ovl) m_q.delete();
            else begin
                m_q.push_back(d);
                if (m_q.size() > ML - 1) void'(m_q.pop_front());
            end
        end
        check("count", {29'b0, match_count}, m_cnt);
        check("armed", {31'b0, armed}, {31'b0, m_armed()});
    endtask
    task automatic load(input int n, input int s[8], input bit o, input bit v = 0, input int d = 0);
        cfg_pattern = '0;
        for (int k = 0; k < ML; k++)
            if (n > ML) cfg_pattern[k*SW +: SW] = s[k][SW-1:0];
            else if (k < n) cfg_pattern[k*SW +: SW] = s[n-1-k][SW-1:0];
        cfg_len = n[LW-1:0];
        cfg_overlap = o;
        pend_len = n;
        pend_ovl = o;
        pend_seq.delete();
        if (n <= ML) for (int j = 0; j < n; j++) pend_seq.push_back(s[j]);
        step(v, d, 1);
    endtask
    task automatic feed(input int s[$], input bit gaps = 0);
        foreach (s[i]) begin
            step(1, s[i]);
            if (gaps) step(0, $urandom_range(0, 3));
        end
    endtask
    function automatic int rsym();
        return ($urandom_range(0, 7) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
    endfunction
    initial begin
        int s[$];
        int rp[8];
        int n;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_match", {31'b0, match}, 0);
        check("rst_count", {29'b0, match_count}, 0);
        check("rst_armed", {31'b0, armed}, 0);
        load(5, '{0, 0, 1, 1, 1, 0, 0, 0}, 0);
        check("prime_armed", {31'b0, armed}, 0);
        hits = 0;
        s = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
        feed(s);
        check("bbccc_hits", hits, 2);
        check("bbccc_cnt", {29'b0, match_count}, 2);
        s = '{1, 0, 1, 0, 1, 0, 1};
        load(3, '{1, 0, 1, 0, 0, 0, 0, 0}, 1);
        hits = 0;
        feed(s);
        check("ovl_hits", hits, 3);
        check("ovl_cnt", {29'b0, match_count}, 3);
        load(3, '{1, 0, 1, 0, 0, 0, 0, 0}, 0);
        hits = 0;
        feed(s);
        check("novl_hits", hits, 2);
        check("novl_cnt", {29'b0, match_count}, 2);
        load(3, '{1, 0, 1, 0, 0, 0, 0, 0}, 1);
        hits = 0;
        feed(s, 1);
        check("gap_hits", hits, 3);
        load(5, '{0, 0, 1, 1, 1, 0, 0, 0}, 0);
        s = '{0, 0, 1, 1};
        feed(s);
        load(5, '{0, 0, 1, 1, 1, 0, 0, 0}, 0, 1, 1);
        check("midload_cnt", {29'b0, match_count}, 0);
        check("midload_armed", {31'b0, armed}, 0);
        hits = 0;
        s = '{0, 0, 1, 1, 1};
        feed(s);
        check("midload_hits", hits, 1);
        load(1, '{1, 0, 0, 0, 0, 0, 0, 0}, 0);
        check("len1_armed", {31'b0, armed}, 1);
        hits = 0;
        s = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        feed(s);
        check("sat_hits", hits, 9);
        check("sat_cnt", {29'b0, match_count}, CMAX);
        load(4, '{3, 0, 2, 1, 0, 0, 0, 0}, 0);
        hits = 0;
        s = '{3, 0, 2, 1};
        feed(s);
        check("prerst_hits", hits, 1);
        step(0, 0, 0, 1);
        check("postrst_cnt", {29'b0, match_count}, 0);
        check("postrst_armed", {31'b0, armed}, 0);
        hits = 0;
        s = '{0, 2, 1};
        feed(s);
        check("postrst_hits", hits, 0);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                n = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15)
                  : ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
                foreach (rp[i]) rp[i] = rsym();
                load(n, rp, $urandom_range(0, 1), $urandom_range(0, 1), rsym());
            end else if ($urandom_range(0, 299) == 0) begin
                step(0, 0, 0, 1);
            end else begin
                step($urandom_range(0, 3) != 0, rsym());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
